// File: rtl/fx_dequant_pipe.sv
// Lossless fixed-point widening converter feeding an elastic valid/ready pipeline.
// Words are widened at entry; DEPTH register stages carry the converted words to the output.
module fx_dequant_pipe #(
  parameter int unsigned IW    = 13,
  parameter int unsigned IF    = 10,
  parameter int unsigned OW    = 18,
  parameter int unsigned OF    = 14,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [IW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic [LW-1:0] o_level
);

  if ((int'(OF) < int'(IF)) || ((int'(OW) - int'(OF)) < (int'(IW) - int'(IF))) ||
      (DEPTH < 1)) begin : g_param_check
    $fatal(1, "fx_dequant_pipe: illegal width/fraction/depth parameters");
  end

  localparam int unsigned Shift = OF - IF;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][OW-1:0] data_q, data_d;
  logic [LW-1:0]            level_q, level_d;

  logic [DEPTH-1:0]         load;
  logic [DEPTH-1:0]         src_valid;
  logic [DEPTH-1:0][OW-1:0] src_data;
  logic [OW-1:0]            conv_data;
  logic                     in_xfer, out_xfer;

  // Sign extension happens through the signed size cast; the shift pads fraction LSBs.
  always_comb begin
    conv_data = OW'($signed(i_data)) << Shift;
  end

  // Stage k may load when the output is ready or any stage at or after k is empty,
  // so an empty stage never blocks anything upstream of it.
  always_comb begin : p_load
    logic full_from;
    load = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      full_from = 1'b1;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j >= k) begin
          full_from = full_from & valid_q[j];
        end
      end
      load[k] = o_ready | ~full_from;
    end
  end

  always_comb begin
    src_valid    = '0;
    src_data     = '0;
    src_valid[0] = i_valid;
    src_data[0]  = conv_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  // Data registers only capture valid words, so an emptied stage keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (load[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          data_d[k] = src_data[k];
        end
      end
    end
  end

  always_comb begin
    in_xfer  = i_valid & load[0];
    out_xfer = valid_q[DEPTH-1] & o_ready;
    level_d  = level_q;
    if (in_xfer && !out_xfer) begin
      level_d = level_q + LW'(1);
    end else if (out_xfer && !in_xfer) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      level_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      level_q <= level_d;
    end
  end

  assign i_ready = load[0];
  assign o_valid = valid_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];
  assign o_level = level_q;

endmodule

// File: tb/tb_fx_dequant_pipe.sv
// Self-checking bench: a DEPTH=2 and a DEPTH=1 instance checked against a queue-based model.
module tb_fx_dequant_pipe;
  localparam int IW = 13;
  localparam int IF = 10;
  localparam int OW = 18;
  localparam int OF = 14;

  logic          clk, rst;
  logic          iv[2], ir[2], ov[2], ordy[2];
  logic [IW-1:0] id[2];
  logic [OW-1:0] od[2];
  logic [1:0]    lv0;
  logic [0:0]    lv1;
  logic          acc[2];

  logic [OW-1:0] q0[$];
  logic [OW-1:0] q1[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IW-1:0] din;
    logic [OW-1:0] dout;
  } vec_t;
  vec_t vt[4];

  fx_dequant_pipe #(.IW(IW), .IF(IF), .OW(OW), .OF(OF), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .i_data(id[0]),
    .o_valid(ov[0]), .o_ready(ordy[0]), .o_data(od[0]), .o_level(lv0)
  );

  fx_dequant_pipe #(.IW(IW), .IF(IF), .OW(OW), .OF(OF), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .i_data(id[1]),
    .o_valid(ov[1]), .o_ready(ordy[1]), .o_data(od[1]), .o_level(lv1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion: value scaled by 2^(OF-IF), kept to OW bits.
  function automatic logic [OW-1:0] conv(input logic [IW-1:0] x);
    int v;
    v = int'($signed(x));
    return OW'(v * (1 << (OF - IF)));
  endfunction

  function automatic int depth_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int level_of(input int s);
    return (s == 0) ? int'(lv0) : int'(lv1);
  endfunction

  // One clock cycle with inputs as currently driven; model tracks accepted words in order.
  task automatic cycle();
    logic          xi[2], xo[2], stl[2];
    logic [OW-1:0] held[2];
    logic [OW-1:0] e;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("i_ready%0d", s), int'(ir[s]),
          int'((qsize(s) < depth_of(s)) || ordy[s]));
      xi[s]   = iv[s] && ir[s];
      xo[s]   = ov[s] && ordy[s];
      stl[s]  = ov[s] && !ordy[s];
      held[s] = od[s];
      acc[s]  = xi[s];
      if (xo[s]) begin
        if (qsize(s) == 0) begin
          chk($sformatf("spurious_out%0d", s), int'(xo[s]), 0);
        end else begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("o_data%0d", s), int'(od[s]), int'(e));
        end
      end
      if (xi[s]) begin
        if (s == 0) q0.push_back(conv(id[s]));
        else        q1.push_back(conv(id[s]));
      end
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("o_level%0d", s), level_of(s), qsize(s));
      if (qsize(s) == 0) chk($sformatf("o_valid_empty%0d", s), int'(ov[s]), 0);
      if (stl[s]) begin
        chk($sformatf("stall_valid%0d", s), int'(ov[s]), 1);
        chk($sformatf("stall_data%0d", s), int'(od[s]), int'(held[s]));
      end
    end
  endtask

  task automatic idle_all();
    for (int s = 0; s < 2; s++) begin
      iv[s]   = 1'b0;
      ordy[s] = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    idle_all();
    while ((qsize(0) != 0 || qsize(1) != 0) && n < 20) begin
      cycle();
      n++;
    end
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("drain_left%0d", s), qsize(s), 0);
      chk($sformatf("drain_ovalid%0d", s), int'(ov[s]), 0);
    end
  endtask

  // Feed 5 words into a stalled pipe, then release and let everything through.
  task automatic backpressure(input int s);
    logic [IW-1:0] w[5];
    int idx = 0;
    int n   = 0;
    idle_all();
    for (int i = 0; i < 5; i++) w[i] = IW'($urandom);
    ordy[s] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iv[s] = 1'b1;
      id[s] = w[idx];
      cycle();
      if (acc[s]) idx++;
      if (c + 1 >= depth_of(s)) chk($sformatf("bp_iready%0d", s), int'(ir[s]), 0);
    end
    chk($sformatf("bp_accepted%0d", s), idx, depth_of(s));
    chk($sformatf("bp_level%0d", s), level_of(s), depth_of(s));
    ordy[s] = 1'b1;
    while (idx < 5 && n < 40) begin
      iv[s] = 1'b1;
      id[s] = w[idx];
      cycle();
      if (acc[s]) idx++;
      n++;
    end
    chk($sformatf("bp_all_accepted%0d", s), idx, 5);
    drain();
  endtask

  initial begin
    vt[0] = '{din: 13'h1000, dout: 18'h30000};
    vt[1] = '{din: 13'h0FFF, dout: 18'h0FFF0};
    vt[2] = '{din: 13'h0001, dout: 18'h00010};
    vt[3] = '{din: 13'h1FFF, dout: 18'h3FFF0};

    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; id[s] = '0; ordy[s] = 1'b1; acc[s] = 1'b0;
    end
    #1 rst = 1'b1;
    #6;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_ovalid%0d", s), int'(ov[s]), 0);
      chk($sformatf("rst_odata%0d", s), int'(od[s]), 0);
      chk($sformatf("rst_level%0d", s), level_of(s), 0);
    end
    #1 rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) chk($sformatf("rst_iready%0d", s), int'(ir[s]), 1);
    @(posedge clk);
    #1;

    // Conversion vectors with latency check on the DEPTH=2 instance.
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1;
      id[0] = vt[i].din;
      cycle();
      iv[0] = 1'b0;
      chk("lat_not_yet", int'(ov[0]), 0);
      cycle();
      chk("lat_valid", int'(ov[0]), 1);
      chk("vec_data", int'(od[0]), int'(vt[i].dout));
    end
    drain();

    // Back-to-back streaming.
    for (int i = 0; i < 100; i++) begin
      iv[0] = 1'b1;
      id[0] = IW'($urandom);
      cycle();
      if (i >= 1) chk("stream_level", int'(lv0), 2);
    end
    drain();

    backpressure(0);

    // Random bubbles and backpressure on both instances.
    for (int i = 0; i < 1000; i++) begin
      for (int s = 0; s < 2; s++) begin
        iv[s]   = 1'($urandom_range(0, 1));
        ordy[s] = 1'($urandom_range(0, 1));
        id[s]   = IW'($urandom);
      end
      cycle();
    end
    drain();

    // Asynchronous reset with two words in flight.
    iv[0]   = 1'b1;
    ordy[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id[0] = IW'($urandom);
      cycle();
    end
    chk("pre_rst_level", int'(lv0), 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_ovalid", int'(ov[0]), 0);
    chk("arst_level", int'(lv0), 0);
    chk("arst_odata", int'(od[0]), 0);
    q0.delete();
    q1.delete();
    idle_all();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b1;
    id[0] = 13'h0005;
    cycle();
    iv[0] = 1'b0;
    chk("post_rst_not_yet", int'(ov[0]), 0);
    cycle();
    chk("post_rst_valid", int'(ov[0]), 1);
    chk("post_rst_data", int'(od[0]), 18'h00050);
    drain();

    // DEPTH=1: visible right after the accepting edge.
    iv[1]   = 1'b1;
    id[1]   = 13'h0FFF;
    ordy[1] = 1'b0;
    cycle();
    iv[1] = 1'b0;
    chk("d1_valid", int'(ov[1]), 1);
    chk("d1_data", int'(od[1]), 18'h0FFF0);
    chk("d1_iready_full", int'(ir[1]), 0);
    drain();
    backpressure(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
